btn_event_arbiter: RTL

Shares one single-cycle `out` strobe among `N_CH` push-button channels. Each channel has a press detector that yields one event per press, with re-arm on release. Events are held as pending requests and granted round-robin, with a programmable minimum gap between strobes and a downstream `busy` back-pressure input. The block sits between the raw button inputs and any consumer that accepts only one event at a time. Each strobe carries the ID of the channel it was granted to.

---
 rtl/btn_event_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter
// Turns raw push-button levels into one event per press, holds the events as
// pending requests and hands them out round-robin as a single-cycle strobe
// tagged with the channel ID. A minimum idle gap follows every strobe, and a
// downstream busy flag blocks new grants while the arbiter is idle.
module btn_event_arbiter #(
  parameter int N_CH = 4,
  parameter int ID_W = 2,
  parameter int GAP  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  input  logic            busy,
  output logic            out,
  output logic [ID_W-1:0] out_id,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] overrun,
  output logic [1:0]      state_test
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_GAP   = 2'b10
  } state_t;

  // Round-robin pick: first set request strictly after ptr, wrapping around.
  // ptr itself is examined last, so the most recent winner has lowest priority.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                              input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] win;
    logic            hit;
    int              idx;
    win = ptr;
    hit = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(ptr) + k) % N_CH;
      if (!hit && req[idx[IDX_W-1:0]]) begin
        win = ID_W'(idx);
        hit = 1'b1;
      end
    end
    return win;
  endfunction

  // Gap counter step; never wraps below zero.
  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: press detectors and pending/overrun request bookkeeping
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0] armed_p0;
  logic [N_CH-1:0] pend_p0;
  logic [N_CH-1:0] ovr_p0;

  // ---------------------------------------------------------------------------
  // Stage p1: arbiter FSM and registered strobe outputs
  // ---------------------------------------------------------------------------
  state_t          state_p1;
  logic            out_p1;
  logic [ID_W-1:0] out_id_p1;
  logic [ID_W-1:0] ptr_p1;
  logic [3:0]      cnt_p1;

  logic [N_CH-1:0] evt;
  logic            gnt;
  logic [ID_W-1:0] win;
  logic [N_CH-1:0] gnt_mask;
  logic [N_CH-1:0] armed_nxt;
  logic [N_CH-1:0] pend_nxt;
  logic [N_CH-1:0] ovr_nxt;

  // Event detection, grant decision and next request state.
  always_comb begin
    evt       = armed_p0 & btn;
    win       = rr_pick(pend_p0, ptr_p1);
    gnt       = (state_p1 == S_IDLE) && (|pend_p0) && !busy;
    gnt_mask  = gnt ? (N_CH'(1) << win) : '0;
    // ARMED stays armed while low and leaves on a press; WAIT_REL re-arms on
    // release and stays while held. Both collapse to "armed iff btn was low".
    armed_nxt = ~btn;
    // A same-edge grant and press on one channel leaves the request set and
    // is not counted as an overrun: the old request was consumed.
    pend_nxt  = (pend_p0 & ~gnt_mask) | evt;
    ovr_nxt   = ovr_p0 | (evt & pend_p0 & ~gnt_mask);
  end

  // Press detector and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_p0 <= '1;
      pend_p0  <= '0;
      ovr_p0   <= '0;
    end else begin
      armed_p0 <= armed_nxt;
      pend_p0  <= pend_nxt;
      ovr_p0   <= ovr_nxt;
    end
  end

  // Arbiter FSM: grant in IDLE, one strobe cycle in ISSUE, then GAP idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1  <= S_IDLE;
      out_p1    <= 1'b0;
      out_id_p1 <= '0;
      ptr_p1    <= PTR_RST;
      cnt_p1    <= 4'd0;
    end else begin
      case (state_p1)
        S_IDLE: begin
          if (gnt) begin
            out_p1    <= 1'b1;
            out_id_p1 <= win;
            ptr_p1    <= win;
            state_p1  <= S_ISSUE;
          end else begin
            out_p1    <= 1'b0;
          end
        end
        S_ISSUE: begin
          out_p1 <= 1'b0;
          if (GAP == 0) begin
            state_p1 <= S_IDLE;
          end else begin
            cnt_p1   <= GAP_LOAD;
            state_p1 <= S_GAP;
          end
        end
        S_GAP: begin
          out_p1 <= 1'b0;
          if (cnt_p1 == 4'd0) begin
            state_p1 <= S_IDLE;
          end else begin
            cnt_p1 <= sat_dec(cnt_p1);
          end
        end
        default: begin
          out_p1   <= 1'b0;
          state_p1 <= S_IDLE;
        end
      endcase
    end
  end

  assign out        = out_p1;
  assign out_id     = out_id_p1;
  assign pending    = pend_p0;
  assign overrun    = ovr_p0;
  assign state_test = state_p1;

  // The strobe is always a single cycle and names a real channel.
  a_single_strobe : assert property (@(posedge clk) disable iff (rst) out_p1 |=> !out_p1);
  a_valid_id      : assert property (@(posedge clk) disable iff (rst) out_p1 |-> (int'(out_id_p1) < N_CH));

endmodule
